// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller and its
// decode-side queue.
package fetch_pkg;

    localparam int AW_DEF      = 16;
    localparam int IW_DEF      = 16;
    localparam int PC_STEP_DEF = 1;
    localparam int QDEPTH      = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} FIFO between fetch and decode; entry 0 is always the
// head, so a pop shifts entry 1 down.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [AW-1:0] push_pc_i,
    input  logic [IW-1:0] push_instr_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [1:0]    count_o,
    output logic          head_valid_o,
    output logic [AW-1:0] head_pc_o,
    output logic [IW-1:0] head_instr_o
);

    logic [1:0]    count_q, count_d;
    logic [AW-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [IW-1:0] in0_q, in0_d, in1_q, in1_d;
    logic          pop, push;

    assign pop  = pop_i && (count_q != 2'd0);
    assign push = push_i && ((count_q < 2'(QDEPTH)) || pop);

    always_comb begin
        count_d = count_q;
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else if (push && pop) begin
            // Count unchanged: new word lands behind whatever stays.
            if (count_q == 2'd1) begin
                pc0_d = push_pc_i;
                in0_d = push_instr_i;
            end else begin
                pc0_d = pc1_q;
                in0_d = in1_q;
                pc1_d = push_pc_i;
                in1_d = push_instr_i;
            end
        end else if (push) begin
            if (count_q == 2'd0) begin
                pc0_d = push_pc_i;
                in0_d = push_instr_i;
            end else begin
                pc1_d = push_pc_i;
                in1_d = push_instr_i;
            end
            count_d = count_q + 2'd1;
        end else if (pop) begin
            pc0_d   = pc1_q;
            in0_d   = in1_q;
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            pc0_q   <= '0;
            pc1_q   <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
        end else begin
            count_q <= count_d;
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_pc_o    = pc0_q;
    assign head_instr_o = in0_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: single-outstanding imem request FSM, next-PC
// selection for the external PC register, and the decode queue.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int IW      = IW_DEF,
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] curr_pc,
    output logic [AW-1:0] next_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          id_valid,
    output logic [IW-1:0] id_instr,
    output logic [AW-1:0] id_pc,
    input  logic          id_ready
);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] held_addr_q, held_addr_d;
    logic [AW-1:0] push_pc;
    logic [1:0]    q_count;
    logic          can_issue;
    logic          push;
    logic          ack_taken;

    assign can_issue = (q_count < 2'(QDEPTH));

    always_comb begin
        state_d     = state_q;
        held_addr_d = held_addr_q;
        imem_req    = 1'b0;
        imem_addr   = held_addr_q;
        push        = 1'b0;
        push_pc     = held_addr_q;
        ack_taken   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!redirect && can_issue) begin
                    imem_req    = 1'b1;
                    imem_addr   = curr_pc;
                    held_addr_d = curr_pc;
                    if (imem_ack) begin
                        push      = 1'b1;
                        push_pc   = curr_pc;
                        ack_taken = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = IDLE;
                    if (!redirect) begin
                        push      = 1'b1;
                        ack_taken = 1'b1;
                    end
                end else if (redirect) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                // Stale request must still complete before a new one may issue.
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            imem_req  = 1'b0;
            push      = 1'b0;
            ack_taken = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            held_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            held_addr_q <= held_addr_d;
        end
    end

    always_comb begin
        if (rst) begin
            next_pc = '0;
        end else if (redirect) begin
            next_pc = redirect_pc;
        end else if (ack_taken) begin
            next_pc = curr_pc + AW'(PC_STEP);
        end else begin
            next_pc = curr_pc;
        end
    end

    fetch_queue #(
        .AW (AW),
        .IW (IW)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_pc_i    (push_pc),
        .push_instr_i (imem_rdata),
        .pop_i        (id_valid && id_ready && !redirect),
        .flush_i      (redirect),
        .count_o      (q_count),
        .head_valid_o (id_valid),
        .head_pc_o    (id_pc),
        .head_instr_o (id_instr)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: external PC register, latency-programmable
// instruction memory, and a scoreboard of fetched words expected at decode.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] curr_pc;
    logic [15:0] next_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        id_ready;

    int          mem_delay;
    bit          mem_stall;
    bit          force_ack;
    int          wait_cnt;

    int          n_chk;
    int          n_err;
    logic [31:0] exp_q[$];
    bit          tb_discard;
    bit          prev_pend;
    logic [15:0] prev_addr;
    logic [15:0] hold_pc;

    fetch_ctrl #(
        .AW      (16),
        .IW      (16),
        .PC_STEP (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .curr_pc     (curr_pc),
        .next_pc     (next_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) curr_pc <= next_pc;

    always_ff @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
    end

    always_comb begin
        imem_ack   = force_ack || (imem_req && !mem_stall && (wait_cnt >= mem_delay));
        imem_rdata = imem_addr ^ 16'hC3A5;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge: predicts what the coming rising edge does.
    task automatic monitor();
        logic [31:0] e;
        logic [15:0] exp_npc;
        if (rst) begin
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_valid", {31'd0, id_valid}, 32'd0);
            chk("rst_next_pc", {16'd0, next_pc}, 32'd0);
            exp_q.delete();
            tb_discard = 1'b0;
            prev_pend  = 1'b0;
            return;
        end
        chk("id_valid", {31'd0, id_valid}, {31'd0, exp_q.size() != 0});
        if (prev_pend) begin
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_held", {16'd0, imem_addr}, {16'd0, prev_addr});
        end
        if (redirect)
            exp_npc = redirect_pc;
        else if (imem_req && imem_ack && !tb_discard)
            exp_npc = curr_pc + 16'd1;
        else
            exp_npc = curr_pc;
        chk("next_pc", {16'd0, next_pc}, {16'd0, exp_npc});
        if (id_valid && id_ready && !redirect && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("id_pc", {16'd0, id_pc}, {16'd0, e[31:16]});
            chk("id_instr", {16'd0, id_instr}, {16'd0, e[15:0]});
        end
        if (redirect)
            exp_q.delete();
        else if (imem_req && imem_ack && !tb_discard)
            exp_q.push_back({imem_addr, imem_rdata});
        prev_pend = imem_req && !imem_ack;
        prev_addr = imem_addr;
        if (imem_ack) tb_discard = 1'b0;
        if (redirect && imem_req && !imem_ack) tb_discard = 1'b1;
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        tb_discard  = 1'b0;
        prev_pend   = 1'b0;
        prev_addr   = '0;
        hold_pc     = '0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b1;
        mem_delay   = 0;
        mem_stall   = 1'b0;
        force_ack   = 1'b0;

        // Reset
        tick(1);
        #1;
        chk("rst_id_pc", {16'd0, id_pc}, 32'd0);
        chk("rst_id_instr", {16'd0, id_instr}, 32'd0);
        chk("rst_req_in", {31'd0, imem_req}, 32'd0);
        tick(2);
        rst = 1'b0;
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", {16'd0, imem_addr}, 32'h0000);
        chk("first_next_pc", {16'd0, next_pc}, 32'h0001);

        // Zero-wait streaming
        tick(6);
        #1;
        chk("stream_id_pc", {16'd0, id_pc}, 32'h0005);
        chk("stream_addr", {16'd0, imem_addr}, 32'h0006);

        // Three-cycle ack delay
        mem_delay = 3;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("dly_req", {31'd0, imem_req}, 32'd1);
            chk("dly_addr", {16'd0, imem_addr}, 32'h0006);
            chk("dly_next_pc", {16'd0, next_pc}, (i == 3) ? 32'h0007 : 32'h0006);
            tick(1);
        end
        mem_delay = 0;

        // Decode stall fills the queue
        id_ready = 1'b0;
        tick(4);
        #1;
        chk("full_req", {31'd0, imem_req}, 32'd0);
        chk("full_valid", {31'd0, id_valid}, 32'd1);
        chk("full_head", {16'd0, id_pc}, 32'h0006);
        tick(1);
        id_ready = 1'b1;
        tick(6);

        // Redirect while WAIT, ack two cycles later
        mem_stall = 1'b1;
        hold_pc   = curr_pc;
        tick(1);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        chk("rd_next_pc", {16'd0, next_pc}, 32'h0040);
        tick(1);
        redirect = 1'b0;
        #1;
        chk("disc_valid", {31'd0, id_valid}, 32'd0);
        chk("disc_addr", {16'd0, imem_addr}, {16'd0, hold_pc});
        tick(1);
        mem_stall = 1'b0;
        #1;
        chk("disc_ack_req", {31'd0, imem_req}, 32'd1);
        chk("disc_ack_npc", {16'd0, next_pc}, 32'h0040);
        tick(1);
        #1;
        chk("post_disc_addr", {16'd0, imem_addr}, 32'h0040);
        chk("post_disc_valid", {31'd0, id_valid}, 32'd0);
        tick(3);

        // Redirect with ack in the same cycle, from WAIT
        id_ready  = 1'b0;
        mem_stall = 1'b1;
        tick(1);
        redirect    = 1'b1;
        redirect_pc = 16'h0080;
        mem_stall   = 1'b0;
        #1;
        chk("rdack_npc", {16'd0, next_pc}, 32'h0080);
        tick(1);
        redirect = 1'b0;
        #1;
        chk("rdack_valid", {31'd0, id_valid}, 32'd0);
        chk("rdack_addr", {16'd0, imem_addr}, 32'h0080);

        // Redirect and ack together with the queue full
        tick(3);
        #1;
        chk("q2_req", {31'd0, imem_req}, 32'd0);
        chk("q2_valid", {31'd0, id_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        force_ack   = 1'b1;
        #1;
        chk("q2_npc", {16'd0, next_pc}, 32'h0100);
        tick(1);
        redirect  = 1'b0;
        force_ack = 1'b0;
        #1;
        chk("q2_flushed", {31'd0, id_valid}, 32'd0);
        chk("q2_addr", {16'd0, imem_addr}, 32'h0100);
        id_ready = 1'b1;
        tick(3);

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick(1);
        redirect = 1'b0;
        #1;
        chk("wrap_addr", {16'd0, imem_addr}, 32'hFFFF);
        chk("wrap_npc", {16'd0, next_pc}, 32'h0000);
        tick(1);
        #1;
        chk("wrap_id_pc", {16'd0, id_pc}, 32'hFFFF);
        chk("wrap_id_instr", {16'd0, id_instr}, {16'd0, 16'hFFFF ^ 16'hC3A5});
        chk("wrap_next_addr", {16'd0, imem_addr}, 32'h0000);

        // Drain
        mem_stall = 1'b1;
        tick(3);
        #1;
        chk("drain_valid", {31'd0, id_valid}, 32'd0);
        chk("drain_sb", exp_q.size(), 32'd0);
        mem_stall = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
